// File: rtl/ula_pkg.sv
// Shared ALU definitions: operand width, serial-subtractor state encoding and
// the bit positions of the {V, N, Z, Bout} flags in the ALU flag register.
// Latency: n/a (types and constants only). Backpressure: n/a.
package ula_pkg;

  localparam int WIDTH = 8;

  // Flag register layout consumed by the ALU flag logic.
  localparam int FLAG_W    = 4;
  localparam int FLAG_BOUT = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SUB  = 1'b1
  } state_t;

  // Place the individual flags at their fixed positions in the flag word.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic v,
                                                   input logic n,
                                                   input logic z,
                                                   input logic bout);
    logic [FLAG_W-1:0] f;
    f            = '0;
    f[FLAG_V]    = v;
    f[FLAG_N]    = n;
    f[FLAG_Z]    = z;
    f[FLAG_BOUT] = bout;
    return f;
  endfunction

endpackage

// File: rtl/subtratorcompleto.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Latency: purely combinational. Backpressure: none.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in) -> d (difference), bout (borrow out).
module subtratorcompleto (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtrator_serial_8bits.sv
// Bit-serial subtractor S = A - B, LSB first, one bit per clock, plus ALU flags.
// Latency: 8 cycles from the accepting edge to S/flags valid with a one-cycle done pulse.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst_n (sync, active-low), start, A, B in; S, Bout, Z, N, V, busy, done out.
module subtrator_serial_8bits
  import ula_pkg::*;
#(
  parameter int WIDTH = ula_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Bout,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t            state_q;
  state_t            state_d;

  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  // Holds the WIDTH-1 bits already produced; the final bit goes straight to S.
  logic [WIDTH-2:0]  res_sh;
  logic [WIDTH-1:0]  res_next;
  logic [CNT_W-1:0]  cnt_q;
  logic              br_q;
  logic              a_msb_q;
  logic              b_msb_q;
  logic              d_bit;
  logic              br_next;
  logic              accept;
  logic              last;
  logic              done_q;
  logic [FLAG_W-1:0] flag_q;
  logic [FLAG_W-1:0] flag_d;

  assign accept = (state_q == IDLE) && start;
  assign last   = (state_q == SUB) && (cnt_q == CNT_LAST);

  // Single shared full subtractor working on the current LSBs.
  subtratorcompleto u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_next)
  );

  assign res_next = {d_bit, res_sh};

  // V uses the MSB copies latched at acceptance, since A/B may change later
  // and the shift registers no longer hold the sign bits by the last cycle.
  assign flag_d = pack_flags((a_msb_q ^ b_msb_q) & (a_msb_q ^ res_next[WIDTH-1]),
                             res_next[WIDTH-1],
                             (res_next == '0),
                             br_next);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SUB;
      SUB:     if (cnt_q == CNT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SUB);
    done = done_q;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (accept) begin
      a_sh    <= A;
      b_sh    <= B;
      res_sh  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= A[WIDTH-1];
      b_msb_q <= B[WIDTH-1];
    end else if (state_q == SUB) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= res_next[WIDTH-1:1];
      br_q   <= br_next;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------- outputs
  // Result and flags only change on completion and otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S      <= '0;
      flag_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (last) begin
        S      <= res_next;
        flag_q <= flag_d;
      end
    end
  end

  assign Bout = flag_q[FLAG_BOUT];
  assign Z    = flag_q[FLAG_Z];
  assign N    = flag_q[FLAG_N];
  assign V    = flag_q[FLAG_V];

endmodule

// File: tb/tb_subtrator_serial_8bits.sv
// Directed bench for the serial subtractor: reset state, handshake timing,
// result/flag values, ignored mid-operation start, back-to-back and abort.
// Latency: n/a. Backpressure: n/a.
module tb_subtrator_serial_8bits;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] S;
  logic       Bout;
  logic       Z;
  logic       N;
  logic       V;
  logic       busy;
  logic       done;

  int n_vec;
  int n_err;

  subtrator_serial_8bits #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .S     (S),
    .Bout  (Bout),
    .Z     (Z),
    .N     (N),
    .V     (V),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Assert start with operands at a negedge; return at the negedge after the
  // accepting edge with start dropped and the operand inputs scrambled.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A     = ~a;
    B     = 8'h5C;
  endtask

  // Called right after the accepting edge: expect 8 busy cycles, then done
  // with the given result. Returns positioned in the done cycle.
  task automatic finish_op(input string tg, input logic [7:0] es, input logic eb,
                           input logic ez, input logic en, input logic ev);
    for (int i = 0; i < 8; i++) begin
      chk({tg, ".busy"}, busy, 1'b1);
      chk({tg, ".done_early"}, done, 1'b0);
      @(negedge clk);
    end
    chk({tg, ".done"}, done, 1'b1);
    chk({tg, ".busy_at_done"}, busy, 1'b0);
    chk({tg, ".S"}, S, es);
    chk({tg, ".Bout"}, Bout, eb);
    chk({tg, ".Z"}, Z, ez);
    chk({tg, ".N"}, N, en);
    chk({tg, ".V"}, V, ev);
  endtask

  initial begin
    int ndone;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = 8'h00;
    B     = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst.S", S, 8'h00);
    chk("rst.flags", {V, N, Z, Bout}, 4'b0000);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic positive difference; done must fall after one cycle.
    issue(8'h35, 8'h12);
    finish_op("t1", 8'h23, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1.done_fall", done, 1'b0);
    chk("t1.S_hold", S, 8'h23);

    // Underflow wraps to FF with borrow.
    issue(8'h00, 8'h01);
    finish_op("t2", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Signed overflow: -128 - 1.
    issue(8'h80, 8'h01);
    finish_op("t3", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // Zero result, then start held through the done cycle for back-to-back.
    issue(8'h5A, 8'h5A);
    finish_op("t4a", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(8'h7F, 8'h80);
    chk("t4b.done_fall", done, 1'b0);
    finish_op("t4b", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);

    // A second start pulse while busy must be ignored.
    issue(8'h10, 8'h01);
    for (int i = 0; i < 8; i++) begin
      chk("t5.busy", busy, 1'b1);
      if (i == 2) begin
        A     = 8'hFF;
        B     = 8'hFF;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("t5.done", done, 1'b1);
    chk("t5.S", S, 8'h0F);
    chk("t5.flags", {V, N, Z, Bout}, 4'b0000);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) ndone++;
    end
    chk("t5.no_extra_op", ndone, 0);

    // Reset during the fifth cycle of an operation aborts it.
    issue(8'h44, 8'h11);
    repeat (4) @(negedge clk);
    chk("t6.busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6.busy", busy, 1'b0);
    chk("t6.done", done, 1'b0);
    chk("t6.S", S, 8'h00);
    chk("t6.flags", {V, N, Z, Bout}, 4'b0000);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t6.no_done", ndone, 0);

    // Recovery after abort.
    issue(8'hC3, 8'h3C);
    finish_op("t7", 8'h87, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t7.done_fall", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
